seg_scan: RTL and testbench
===========================

SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter NUM_DIGITS, default 8: number of multiplexed 7-segment digits, legal range 1..16.
REQ-002 Parameter SCAN_DIV, default 1000: clk cycles each digit stays lit, legal range 2..65535.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 digits  input  NUM_DIGITS*4  hex value per digit; digit i occupies bits [4i+3:4i], digit 0 rightmost.
REQ-006 dp_mask  input  NUM_DIGITS  decimal-point request per digit, 1 = lit.
REQ-007 load  input  1  one-cycle strobe; snapshot digits and dp_mask.
REQ-008 seg_n  output  8  active-low segments; bit0..6 = a..g, bit7 = dp.
REQ-009 an_n  output  NUM_DIGITS  active-low one-hot digit enable.
REQ-010 frame_done  output  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to digit 0.

Function
REQ-011 Snapshot registers SHALL capture digits/dp_mask on the edge where load=1 and hold them otherwise; the display SHALL never read digits/dp_mask directly.
REQ-012 Prescaler SHALL count 0..SCAN_DIV-1 and wrap to 0; its width SHALL be $clog2(SCAN_DIV).
REQ-013 Digit index SHALL advance by 1 on the edge where the prescaler is at SCAN_DIV-1, wrapping NUM_DIGITS-1 -> 0.
REQ-014 frame_done SHALL be 1 for exactly the one cycle after the index wraps to 0; with NUM_DIGITS=1 it SHALL pulse once per SCAN_DIV cycles.
REQ-015 an_n and seg_n SHALL be registered, reflecting the index and snapshot of the previous cycle (1-cycle latency).
REQ-016 an_n SHALL drive low only the bit of the current index; exactly one bit low at all times outside reset.
REQ-017 seg_n[6:0] SHALL be the inverted full hex decode 0-F (0 -> 7'h40, 1 -> 7'h79, 8 -> 7'h00, F -> 7'h0E).
REQ-018 seg_n[7] SHALL equal the inverted snapshot dp_mask bit of the current index.
REQ-019 load on the same edge as an index advance: the newly lit digit SHALL show the new snapshot (visible 2 cycles after the load edge).
REQ-020 load held high for multiple cycles SHALL re-capture every cycle; no other effect on scanning.

Reset
REQ-021 While rst=1: prescaler 0, index 0, snapshot all 0, an_n all 1, seg_n 8'hFF, frame_done 0.
REQ-022 First cycle after rst deasserts: an_n = ~1 (digit 0), seg_n = 8'hC0.
REQ-023 rst mid-scan SHALL abort the current digit; scanning restarts at digit 0 with full SCAN_DIV dwell.

Configuration
REQ-024 Macro SEG_SCAN_LZB_EN defined: leading-zero blanking; any digit above the highest nonzero snapshot digit SHALL output seg_n[6:0]=7'h7F, digit 0 never blanked, dp unaffected.
REQ-025 SEG_SCAN_LZB_EN undefined: all digits decoded per REQ-017; no blanking logic synthesized.

Structure
REQ-026 Package seg_scan_pkg SHALL hold the 16-entry segment pattern constant table, SEG_BLANK (7'h7F) and the segment bit-order localparams.
REQ-027 Combinational sub-module seg_decode (4-bit hex in, 7-bit active-low segments out) SHALL implement the table; seg_scan instantiates it once.
REQ-028 Leading-zero mask SHALL be computed combinationally from the snapshot, not per-digit-time.

Verification (bench: NUM_DIGITS=4, SCAN_DIV=4)
REQ-029 Reset release, no load -> an_n 4'b1110, 4'b1101, 4'b1011, 4'b0111, each 4 cycles, seg_n 8'hC0 throughout; frame_done pulses every 16 cycles.
REQ-030 load with digits=16'h12AF, dp_mask=4'b0100 -> digit0 seg_n 8'h8E, digit1 8'h88, digit2 8'h24 (dp lit), digit3 8'hF9.
REQ-031 load asserted on the edge the index advances 0->1 with digits=16'h0050 -> digit1 shows 8'h92 on its first lit cycle.
REQ-032 rst pulsed in 3rd cycle of digit 2 -> outputs 8'hFF/4'b1111 during rst, then digit 0 for full 4 cycles, snapshot cleared.
REQ-033 SEG_SCAN_LZB_EN defined, digits=16'h0030 -> digits 3,2 seg_n 8'hFF, digit1 8'hB0, digit0 8'hC0; digits=16'h0000 -> only digit0 shows 8'hC0.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared constants for the seg_scan display driver: segment bit order,
// the active-low hex glyph table and the blank pattern.
package seg_scan_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low glyphs, bit0..6 = a..g, indexed by hex value.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg_scan_if.sv
// Display bus of seg_scan: snapshot inputs from the host, multiplexed
// active-low segment/anode drive and the frame pulse back.
interface seg_scan_if #(
    parameter int NUM_DIGITS = 8
);
    logic [NUM_DIGITS*4-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp_mask;
    logic                    load;
    logic [7:0]              seg_n;
    logic [NUM_DIGITS-1:0]   an_n;
    logic                    frame_done;

    modport master (
        output digits, dp_mask, load,
        input  seg_n, an_n, frame_done
    );

    modport slave (
        input  digits, dp_mask, load,
        output seg_n, an_n, frame_done
    );
endinterface

// File: rtl/seg_scan_decode.sv
// Combinational hex to active-low 7-segment decoder (module seg_decode).
module seg_decode
    import seg_scan_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seg_scan.sv
// Multiplexed 7-segment scanner with load-strobed snapshot and registered outputs.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 1000
)(
    input  logic        clk,
    input  logic        rst,
    seg_scan_if.slave   bus
);

    localparam int PRESC_W = $clog2(SCAN_DIV);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_MAX   = IDX_W'(NUM_DIGITS - 1);

    logic [PRESC_W-1:0]      presc_r;
    logic [IDX_W-1:0]        idx_r;
    logic [NUM_DIGITS*4-1:0] digits_r;
    logic [NUM_DIGITS-1:0]   dp_r;
    logic [7:0]              seg_n_r;
    logic [NUM_DIGITS-1:0]   an_n_r;
    logic                    frame_done_r;

    logic                    tick_s;
    logic                    wrap_s;
    logic [3:0]              hex_s;
    logic                    dp_s;
    logic [NUM_DIGITS-1:0]   an_n_s;
    logic [6:0]              dec_s;
    logic                    blank_cur_s;
    logic [6:0]              glyph_s;

    assign tick_s = (presc_r == PRESC_MAX);
    assign wrap_s = tick_s && (idx_r == IDX_MAX);

    // Snapshot of the host value; the display path reads only these registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            digits_r <= '0;
            dp_r     <= '0;
        end else if (bus.load) begin
            digits_r <= bus.digits;
            dp_r     <= bus.dp_mask;
        end else begin
            digits_r <= digits_r;
            dp_r     <= dp_r;
        end
    end

    // Dwell prescaler and digit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= '0;
            idx_r   <= '0;
        end else if (tick_s) begin
            presc_r <= '0;
            idx_r   <= wrap_s ? '0 : idx_r + IDX_W'(1'b1);
        end else begin
            presc_r <= presc_r + PRESC_W'(1'b1);
            idx_r   <= idx_r;
        end
    end

    // Select the current digit's nibble, dp bit and one-hot anode.
    always_comb begin
        hex_s  = 4'h0;
        dp_s   = 1'b0;
        an_n_s = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_r == IDX_W'(i)) begin
                hex_s     = digits_r[4*i +: 4];
                dp_s      = dp_r[i];
                an_n_s[i] = 1'b0;
            end else begin
                an_n_s[i] = 1'b1;
            end
        end
    end

    seg_decode u_decode (
        .hex (hex_s),
        .seg (dec_s)
    );

`ifdef SEG_SCAN_LZB_EN
    logic [NUM_DIGITS-1:0] blank_s;
    logic                  upper_zero_s;

    // Digit i blanks when it and every digit above it are zero; digit 0 never blanks.
    always_comb begin
        blank_s      = '0;
        upper_zero_s = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            upper_zero_s = upper_zero_s & (digits_r[4*i +: 4] == 4'h0);
            blank_s[i]   = upper_zero_s;
        end
    end

    assign blank_cur_s = |(blank_s & ~an_n_s);
`else
    assign blank_cur_s = 1'b0;
`endif

    assign glyph_s = blank_cur_s ? SEG_BLANK : dec_s;

    // Registered display drive and frame pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            an_n_r       <= '1;
            seg_n_r      <= 8'hFF;
            frame_done_r <= 1'b0;
        end else begin
            an_n_r           <= an_n_s;
            seg_n_r[SEG_DP]  <= ~dp_s;
            seg_n_r[6:0]     <= glyph_s;
            frame_done_r     <= wrap_s;
        end
    end

    assign bus.seg_n      = seg_n_r;
    assign bus.an_n       = an_n_r;
    assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_seg_scan.sv
// Randomized scoreboard bench for seg_scan (NUM_DIGITS=4, SCAN_DIV=4);
// the model follows SEG_SCAN_LZB_EN when it is defined.
module tb_seg_scan;

    localparam int ND = 4;
    localparam int SD = 4;

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
        logic       fd;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    seg_scan_if #(.NUM_DIGITS(ND)) bus ();

    seg_scan #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;

    // model state: edges since reset and current snapshot
    int          n = 0;
    logic [15:0] snap_d  = 16'h0000;
    logic [3:0]  snap_dp = 4'h0;

    // Lit segments per hex glyph, written as the segment letters.
    string segs [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                         "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    function automatic logic [6:0] glyph(input logic [15:0] snap, input int idx);
        logic [6:0] bits;
        logic [3:0] h;
        string      s;
        byte        c;
        h    = 4'((snap >> (4 * idx)) & 16'h000F);
        bits = 7'h7F;
        s    = segs[h];
        for (int k = 0; k < s.len(); k++) begin
            c = s[k];
            bits[int'(c) - 97] = 1'b0;
        end
`ifdef SEG_SCAN_LZB_EN
        if (idx > 0 && (snap >> (4 * idx)) == 16'h0000) bits = 7'h7F;
`endif
        return bits;
    endfunction

    task automatic step(input logic r, input logic l, input logic [15:0] d, input logic [3:0] p);
        exp_t e;
        int   idx;
        rst          = r;
        bus.load     = l;
        bus.digits   = d;
        bus.dp_mask  = p;
        if (r) begin
            e.an    = 4'hF;
            e.seg   = 8'hFF;
            e.fd    = 1'b0;
            n       = 0;
            snap_d  = 16'h0000;
            snap_dp = 4'h0;
        end else begin
            idx   = (n / SD) % ND;
            e.an  = 4'hF ^ 4'(1 << idx);
            e.seg = {~snap_dp[idx], glyph(snap_d, idx)};
            e.fd  = (((n + 1) % (SD * ND)) == 0);
            n++;
            if (l) begin
                snap_d  = d;
                snap_dp = p;
            end
        end
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) step(1'b0, 1'b0, 16'($urandom), 4'($urandom));
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    // Monitor: one expected response per clock edge.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (q.size() == 0) begin
            chk("scoreboard_underflow", 8'h01, 8'h00);
        end else begin
            e = q.pop_front();
            chk("an_n", {4'h0, bus.an_n}, {4'h0, e.an});
            chk("seg_n", bus.seg_n, e.seg);
            chk("frame_done", {7'h00, bus.frame_done}, {7'h00, e.fd});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] d;
        int          guard;
        rst = 1'b1;
        bus.load = 1'b0;
        bus.digits = 16'h0000;
        bus.dp_mask = 4'h0;
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 16'h0000, 4'h0);

        // free-running scan after reset, no load
        idle(40);

        // mixed glyphs with a dp on digit 2
        step(1'b0, 1'b1, 16'h12AF, 4'b0100);
        idle(20);

        // load on the edge where the index advances 0 -> 1
        guard = 0;
        while ((n % 16) != 3 && guard < 32) begin
            idle(1);
            guard++;
        end
        step(1'b0, 1'b1, 16'h0050, 4'h0);
        idle(10);

        // reset during the 3rd cycle of digit 2
        step(1'b0, 1'b1, 16'hBEEF, 4'hF);
        guard = 0;
        while ((n % 16) != 10 && guard < 32) begin
            idle(1);
            guard++;
        end
        step(1'b1, 1'b0, 16'h1234, 4'hA);
        idle(20);

        // leading-zero patterns
        step(1'b0, 1'b1, 16'h0030, 4'h0);
        idle(17);
        step(1'b0, 1'b1, 16'h0000, 4'h0);
        idle(17);

        // held load re-captures every cycle
        for (int k = 0; k < 12; k++) step(1'b0, 1'b1, 16'($urandom), 4'($urandom));
        idle(8);

        // random traffic, digits biased toward zeros
        for (int k = 0; k < 400; k++) begin
            d = 16'h0000;
            for (int j = 0; j < ND; j++)
                if ($urandom_range(1) == 1) d[4*j +: 4] = 4'($urandom);
            step($urandom_range(99) == 0, $urandom_range(7) == 0, d, 4'($urandom));
        end

        total++;
        if (q.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
